// File: rtl/seq_detect_param_pkg.sv
// Shared types and constants for the parametrised sequence detector.
// The optional match counter is enabled by defining SEQ_MATCH_CNT_EN.
package seq_detect_param_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam int             MATCH_CNT_W   = 8;
    localparam logic [7:0]     MATCH_CNT_MAX = 8'hFF;

    // Width of a counter that must hold values 0..depth inclusive.
    function automatic int fill_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Symbol/pattern bus between a symbol source (master) and the detector (slave).
// match_cnt is present only when SEQ_MATCH_CNT_EN is defined.
interface seq_detect_param_if #(
    parameter int W     = 2,
    parameter int DEPTH = 3
);
    import seq_detect_param_pkg::*;

    // No backpressure: a symbol is consumed on every clock edge where
    // x_valid=1 and pat_load=0; the detector never stalls the source.
    logic                 x_valid;
    logic [W-1:0]         x_in;
    logic                 pat_load;
    logic [W*DEPTH-1:0]   pat_in;
    logic                 overlap;
    logic                 y_out;
    state_t               dbg_state;
`ifdef SEQ_MATCH_CNT_EN
    logic [MATCH_CNT_W-1:0] match_cnt;

    modport master (
        output x_valid, x_in, pat_load, pat_in, overlap,
        input  y_out, dbg_state, match_cnt
    );
    modport slave (
        input  x_valid, x_in, pat_load, pat_in, overlap,
        output y_out, dbg_state, match_cnt
    );
`else
    modport master (
        output x_valid, x_in, pat_load, pat_in, overlap,
        input  y_out, dbg_state
    );
    modport slave (
        input  x_valid, x_in, pat_load, pat_in, overlap,
        output y_out, dbg_state
    );
`endif

endinterface

// File: rtl/seq_detect_param_sym_hist_shift.sv
// Symbol history (newest DEPTH-1 symbols, newest in the top slice) plus a
// fill counter saturating at DEPTH; clr takes priority over shift_en.
module sym_hist_shift
    import seq_detect_param_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           shift_en,
    input  logic                           clr,
    input  logic [W-1:0]                   sym_in,
    output logic [W*(DEPTH-1)-1:0]         hist,
    output logic [fill_w(DEPTH)-1:0]       fill
);
    localparam int                HIST_W   = W * (DEPTH - 1);
    localparam int                FILL_W   = fill_w(DEPTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    logic [HIST_W-1:0] hist_q, hist_d, shifted;
    logic [FILL_W-1:0] fill_q, fill_d;

    // The oldest retained symbol drops out of the bottom slice.
    generate
        if (DEPTH > 2) begin : g_multi
            assign shifted = {sym_in, hist_q[HIST_W-1:W]};
        end else begin : g_single
            assign shifted = sym_in;
        end
    endgenerate

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = shifted;
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist = hist_q;
    assign fill = fill_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised sequence detector: pulses y_out when the last DEPTH accepted
// symbols equal the loaded pattern. SEQ_MATCH_CNT_EN adds a saturating match counter.
module seq_detect_param
    import seq_detect_param_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 3,
    parameter int MEALY = 0
) (
    input  logic               clk,
    input  logic               rst,
    seq_detect_param_if.slave  bus
);
    localparam int                FILL_W   = fill_w(DEPTH);
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(DEPTH - 1);

    logic [W*(DEPTH-1)-1:0] hist;
    logic [FILL_W-1:0]      fill;
    logic [W*DEPTH-1:0]     window;
    logic                   accept;
    logic                   match;
    logic                   hist_clr;

    state_t                 state_q, state_d;
    logic                   y_q, y_d;
    logic [W*DEPTH-1:0]     pat_q, pat_d;

    // A load on the same edge as a symbol drops the symbol.
    assign accept   = bus.x_valid & ~bus.pat_load;
    assign window   = {bus.x_in, hist};
    assign match    = accept && (fill >= FILL_ARM) && (window == pat_q);
    assign hist_clr = bus.pat_load | (match & ~bus.overlap);

    sym_hist_shift #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .clr      (hist_clr),
        .sym_in   (bus.x_in),
        .hist     (hist),
        .fill     (fill)
    );

    always_comb begin
        state_d = state_q;
        y_d     = match;
        pat_d   = bus.pat_load ? bus.pat_in : pat_q;
        if (bus.pat_load) begin
            state_d = ST_FILL;
        end else if (accept) begin
            if (match && !bus.overlap) begin
                state_d = ST_FILL;
            end else if (state_q == ST_FILL && fill == FILL_ARM) begin
                state_d = ST_ARMED;
            end
        end
    end

`ifdef SEQ_MATCH_CNT_EN
    logic [MATCH_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.pat_load) begin
            cnt_d = '0;
        end else if (match && cnt_q != MATCH_CNT_MAX) begin
            cnt_d = cnt_q + MATCH_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_cnt = cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            y_q     <= 1'b0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            pat_q   <= pat_d;
        end
    end

    // Mealy output is masked during reset so it never glitches high under rst.
    always_comb begin
        if (MEALY != 0) begin
            bus.y_out = match & ~rst;
        end else begin
            bus.y_out = y_q;
        end
    end

    assign bus.dbg_state = state_q;

endmodule
